// File: rtl/spi_reg_bridge.sv
// SPI command decoder and register file behind the SPI slave shift core.
// Define SPI_REG_AUTOINC_EN for sequential bursts; otherwise the address stays fixed per transaction.
module spi_reg_bridge #(
  parameter  int WIDTH  = 8,
  parameter  int NREGS  = 16,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cs_n,
  input  logic [WIDTH-1:0]       i_rx_data,
  input  logic                   i_rx_valid,
  output logic [WIDTH-1:0]       o_tx_data,
  output logic                   o_tx_write,
  output logic [NREGS*WIDTH-1:0] o_reg_out,
  output logic                   o_wr_strobe,
  output logic [ADDR_W-1:0]      o_wr_addr
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WRITE, S_READ} state_t;

  state_t                        r_state, w_state_nxt;
  logic                          r_cs_n_q;
  logic [ADDR_W-1:0]             r_addr, w_addr_nxt, w_addr_adv;
  logic [NREGS-1:0][WIDTH-1:0]   r_regs;
  logic [WIDTH-1:0]              r_tx_data, w_tx_word;
  logic                          r_tx_write, r_wr_strobe;
  logic [ADDR_W-1:0]             r_wr_addr;
  logic                          w_wr_en, w_tx_load, w_tx_zero;

`ifdef SPI_REG_AUTOINC_EN
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  // ADDR_W-bit add wraps NREGS-1 -> 0 for free
  assign w_addr_adv = r_addr + ADDR_ONE;
`else
  assign w_addr_adv = r_addr;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wr_en     = 1'b0;
    w_tx_load   = 1'b0;
    w_tx_zero   = 1'b0;
    // cs_n high aborts from any state and swallows a coincident rx word
    if (i_cs_n) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (r_cs_n_q) begin
          w_state_nxt = S_CMD;
          w_tx_load   = 1'b1;
          w_tx_zero   = 1'b1;
        end
        S_CMD: if (i_rx_valid) begin
          w_addr_nxt = i_rx_data[ADDR_W-1:0];
          if (i_rx_data[WIDTH-1]) begin
            w_state_nxt = S_READ;
            w_tx_load   = 1'b1;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end
        S_WRITE: if (i_rx_valid) begin
          w_wr_en    = 1'b1;
          w_addr_nxt = w_addr_adv;
        end
        S_READ: if (i_rx_valid) begin
          w_addr_nxt = w_addr_adv;
          w_tx_load  = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_tx_word = w_tx_zero ? '0 : r_regs[w_addr_nxt];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // low so a cs_n already held low across reset does not start a command
      r_cs_n_q    <= 1'b0;
      r_addr      <= '0;
      r_regs      <= '0;
      r_tx_data   <= '0;
      r_tx_write  <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      r_cs_n_q    <= i_cs_n;
      r_addr      <= w_addr_nxt;
      r_tx_write  <= w_tx_load;
      r_wr_strobe <= w_wr_en;
      if (w_tx_load) r_tx_data <= w_tx_word;
      if (w_wr_en) begin
        r_regs[r_addr] <= i_rx_data;
        r_wr_addr      <= r_addr;
      end
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_write  = r_tx_write;
  assign o_reg_out   = r_regs;
  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_addr   = r_wr_addr;

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Sits directly downstream of the SPI slave shift core, in the same clock domain.
- Consumes each received byte and interprets the byte stream as register-access commands.
- Maintains a small register file that the rest of the design reads.
- Feeds read data back into the core's transmit shift register, giving the SPI master burst read/write access to NREGS registers.

Parameters:
- WIDTH, 8, SPI word width; must match the shift core and be >= ADDR_W+1.
- NREGS, 16, number of registers; power of two, >= 2. ADDR_W = $clog2(NREGS).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cs_n  in  1  SPI chip select, already synchronised to clk; high = transaction idle/ended.
- rx_data  in  WIDTH  received word from the shift core.
- rx_valid  in  1  single-cycle pulse: rx_data holds a newly completed word.
- tx_data  out  WIDTH  word to load into the core's transmit shift register.
- tx_write  out  1  single-cycle load strobe for tx_data.
- reg_out  out  NREGS*WIDTH  flat register file; register i occupies bits [i*WIDTH +: WIDTH].
- wr_strobe  out  1  single-cycle pulse: a register was written by SPI.
- wr_addr  out  ADDR_W  index of the register written; valid while wr_strobe is high.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - all registers, tx_data, wr_addr = 0
  - tx_write, wr_strobe = 0
  - internal address = 0
  - state = IDLE
- Command word format:
  - bit[WIDTH-1] = R/nW (1 = read).
  - bits[ADDR_W-1:0] = start address.
  - Remaining bits are ignored.
- States:
  - IDLE: cs_n high. On cs_n 1->0 (detected on a registered copy of cs_n): go to CMD; next cycle pulse tx_write with tx_data = 0, so MISO shifts zeros during the command word.
  - CMD: on rx_valid, latch address = rx_data[ADDR_W-1:0].
    - R/nW = 0: go to WRITE.
    - R/nW = 1: go to READ; in the following cycle pulse tx_write with tx_data = reg[address].
  - WRITE: on each rx_valid:
    - reg[address] <= rx_data (visible on reg_out the next cycle).
    - wr_strobe = 1 and wr_addr = address in that next cycle.
    - Advance address (see Optional Feature).
  - READ: on each rx_valid:
    - Received word is discarded.
    - Advance address.
    - Next cycle: tx_write = 1, tx_data = reg[new address].
- Address wrap: address arithmetic is modulo NREGS (NREGS-1 -> 0).
- Latency: every tx_write/wr_strobe occurs exactly 1 clk after its triggering rx_valid or cs_n edge. The SPI master must leave at least 3 clk between a word's last rising SCLK edge and the next falling SCLK edge.
- cs_n high in any state:
  - Return to IDLE the same cycle.
  - A partial burst keeps all writes already done.
- Simultaneous rx_valid and cs_n high: cs_n wins; the word is discarded, with no write and no tx_write.
- cs_n is ignored while rst is high.
- tx_write and wr_strobe are never high for more than one consecutive cycle per event.

Optional Feature:
- Macro: SPI_REG_AUTOINC_EN.
- Defined: address increments (mod NREGS) after every data word in WRITE and READ, giving sequential bursts.
- Undefined:
  - Address stays fixed for the whole transaction; repeated words target the same register (FIFO-port style).
  - In READ, tx_data reloads with the same register each word.

Test Plan:
- Reset mid-WRITE burst: assert rst while in WRITE after two words -> all reg_out = 0, tx_write = 0, wr_strobe = 0, state IDLE immediately without a clk edge.
- Single write: cs_n low, words 0x03, 0xA5, cs_n high -> reg_out[3] = 0xA5, one wr_strobe with wr_addr = 3, other registers 0.
- Burst write with wrap (AUTOINC_EN, NREGS = 16): 0x0E, 0x11, 0x22, 0x33 -> reg14 = 0x11, reg15 = 0x22, reg0 = 0x33, three wr_strobe pulses with wr_addr 14, 15, 0.
- Read after write: preload reg5 = 0x5C, reg6 = 0xC3; send 0x85, 0x00, 0x00 -> tx_write one clk after each rx_valid with tx_data 0x5C then 0xC3; an initial 0x00 load after cs_n falls.
- Abort: 0x02, then cs_n high coincident with rx_valid of 0x77 -> reg2 unchanged, no wr_strobe, state IDLE; next transaction decodes a fresh command word.
- Fixed-address mode (macro undefined): 0x04, 0x10, 0x20 -> reg4 = 0x20, reg5 = 0, two wr_strobe pulses both with wr_addr = 4.
